// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types and helpers for the SR flag arbiter: op encodings, width helper
// and the apply-stage command record (sized for the largest supported bank/requester count).
package sr_ctrl_pkg;

  localparam logic OP_RESET = 1'b0;
  localparam logic OP_SET   = 1'b1;

  localparam int CMD_IDXW = 8;  // covers NFLAG up to 256
  localparam int CMD_IDW  = 4;  // covers NREQ up to 16

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                op;
    logic [CMD_IDXW-1:0] idx;
    logic [CMD_IDW-1:0]  id;
  } sr_cmd_t;

endpackage

// File: rtl/sr_flag_arbiter_rr.sv
// Round-robin arbiter: scans requests starting at an internal pointer and
// moves the pointer past the winner whenever the grant is consumed.
module rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDW_L = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDW_L-1:0] gnt_id
);

  logic [IDW_L-1:0] ptr_q, ptr_d;
  logic             found;
  int               j;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = IDW_L'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of SR flags shared by NREQ requesters: round-robin accept, one-stage
// apply pipeline with per-command ack, sticky error for out-of-range indices.
module sr_flag_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NFLAG = 8,
  localparam int IDXW  = clog2_min1(NFLAG),
  localparam int IDW   = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_all,
  output logic [NFLAG-1:0]     flags,
  output logic                 ack_valid,
  output logic [IDW-1:0]       ack_id,
  output logic                 err
);

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             accept;

  sr_cmd_t          stage_q, stage_d;
  logic             stage_v_q, stage_v_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic             err_q, err_d;
  logic             ack_v_q, ack_v_d;
  logic [IDW-1:0]   ack_id_q, ack_id_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // A clear cycle accepts nothing, so the pointer also holds.
  assign req_ready = (clr_all || !rst_n) ? '0 : gnt;
  assign accept    = |req_ready;

  always_comb begin
    stage_d   = stage_q;
    stage_v_d = accept;
    flags_d   = flags_q;
    err_d     = err_q;
    ack_v_d   = 1'b0;
    ack_id_d  = ack_id_q;
    if (accept) begin
      stage_d.op  = req_op[gnt_id];
      stage_d.idx = CMD_IDXW'(req_idx[gnt_id*IDXW +: IDXW]);
      stage_d.id  = CMD_IDW'(gnt_id);
    end
    if (stage_v_q) begin
      ack_v_d  = 1'b1;
      ack_id_d = IDW'(stage_q.id);
      if (int'(stage_q.idx) < NFLAG) flags_d[stage_q.idx[IDXW-1:0]] = stage_q.op;
      else                           err_d = 1'b1;
    end
    if (clr_all) begin
      flags_d   = '0;
      err_d     = 1'b0;
      stage_v_d = 1'b0;
      ack_v_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= '0;
      stage_v_q <= 1'b0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      ack_v_q   <= 1'b0;
      ack_id_q  <= '0;
    end else begin
      stage_q   <= stage_d;
      stage_v_q <= stage_v_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
      ack_v_q   <= ack_v_d;
      ack_id_q  <= ack_id_d;
    end
  end

  assign flags     = flags_q;
  assign err       = err_q;
  assign ack_valid = ack_v_q;
  assign ack_id    = ack_id_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: two instances (8 and 6 flags) share one stimulus
// stream and are compared every cycle against a behavioural model of the bank.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_op = '0;
  logic [11:0] req_idx = '0;
  logic        clr_all = 1'b0;

  logic [3:0]  rdy8, rdy6;
  logic [7:0]  flags8;
  logic [5:0]  flags6;
  logic        ackv8, ackv6, err8, err6;
  logic [1:0]  ackid8, ackid6;

  int checks = 0;
  int errors = 0;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(rdy8), .clr_all(clr_all), .flags(flags8), .ack_valid(ackv8),
    .ack_id(ackid8), .err(err8));

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(rdy6), .clr_all(clr_all), .flags(flags6), .ack_valid(ackv6),
    .ack_id(ackid6), .err(err6));

  always #5 clk = ~clk;

  // Model: round-robin pointer, one pending command, the two banks and their errors.
  int       m_rr, m_sidx, m_sid, m_ackid, m_acc;
  bit       m_sv, m_sop, m_ackv, m_err8, m_err6;
  bit [7:0] m_f8;
  bit [5:0] m_f6;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_sv = 0; m_sop = 0; m_sidx = 0; m_sid = 0;
    m_ackv = 0; m_ackid = 0; m_err8 = 0; m_err6 = 0; m_f8 = '0; m_f6 = '0; m_acc = -1;
  endtask

  function automatic int model_grant();
    if (!rst_n || clr_all) return -1;
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_rr + k) % 4]) return (m_rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_update();
    int g;
    m_acc = -1;
    if (!rst_n) return;
    g = model_grant();
    if (clr_all) begin
      m_f8 = '0; m_f6 = '0; m_err8 = 0; m_err6 = 0; m_sv = 0; m_ackv = 0;
      return;
    end
    m_ackv = m_sv;
    if (m_sv) begin
      m_ackid = m_sid;
      if (m_sidx < 8) m_f8[m_sidx] = m_sop; else m_err8 = 1;
      if (m_sidx < 6) m_f6[m_sidx] = m_sop; else m_err6 = 1;
    end
    if (g >= 0) begin
      m_sv = 1; m_sop = req_op[g]; m_sidx = int'(req_idx[g*3 +: 3]); m_sid = g;
      m_rr = (g + 1) % 4; m_acc = g;
    end else begin
      m_sv = 0;
    end
  endtask

  task automatic check();
    int g;
    logic [3:0] exp_rdy;
    g = model_grant();
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    expect_eq("ready8", 32'(rdy8), 32'(exp_rdy));
    expect_eq("ready6", 32'(rdy6), 32'(exp_rdy));
    expect_eq("flags8", 32'(flags8), 32'(m_f8));
    expect_eq("flags6", 32'(flags6), 32'(m_f6));
    expect_eq("err8", 32'(err8), 32'(m_err8));
    expect_eq("err6", 32'(err6), 32'(m_err6));
    expect_eq("ackv8", 32'(ackv8), 32'(m_ackv));
    expect_eq("ackv6", 32'(ackv6), 32'(m_ackv));
    if (m_ackv) begin
      expect_eq("ackid8", 32'(ackid8), 32'(m_ackid));
      expect_eq("ackid6", 32'(ackid6), 32'(m_ackid));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input bit op, input int idx);
    req_op[i] = op;
    req_idx[i*3 +: 3] = 3'(idx);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset then idle
    for (int c = 0; c < 5; c++) begin
      cycle();
      expect_eq("idle_flags", 32'(flags8), 32'h00);
      expect_eq("idle_ready", 32'(rdy8), 32'h0);
      expect_eq("idle_ackv", 32'(ackv8), 32'h0);
      expect_eq("idle_err", 32'(err8), 32'h0);
    end

    // Single set: requester 2, SET idx 5
    set_req(2, 1'b1, 5); req_valid = 4'b0100; #1;
    expect_eq("single_ready", 32'(rdy8), 32'b0100);
    cycle();
    req_valid = 4'b0000;
    cycle();
    expect_eq("single_flags", 32'(flags8), 32'h20);
    expect_eq("single_ackv", 32'(ackv8), 32'h1);
    expect_eq("single_ackid", 32'(ackid8), 32'h2);
    cycle();
    expect_eq("single_ack_pulse", 32'(ackv8), 32'h0);

    // Fairness from rr_ptr = 0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, i);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      expect_eq("fair_grant", 32'(rdy8), 32'(4'b0001 << (c % 4)));
      cycle();
    end
    expect_eq("fair_flags", 32'(flags8), 32'h0F);
    expect_eq("fair_ackid", 32'(ackid8), 32'h3);
    req_valid = 4'b0000;
    cycle(); cycle();

    // Conflict: SET and RESET of flag 3 in the same cycle
    do_reset();
    set_req(0, 1'b1, 3); set_req(1, 1'b0, 3); req_valid = 4'b0011; #1;
    expect_eq("conf_ready0", 32'(rdy8), 32'b0001);
    cycle();
    req_valid = 4'b0010; #1;
    expect_eq("conf_ready1", 32'(rdy8), 32'b0010);
    cycle();
    expect_eq("conf_ack0", 32'(ackid8), 32'h0);
    expect_eq("conf_set", 32'(flags8[3]), 32'h1);
    req_valid = 4'b0000;
    cycle();
    expect_eq("conf_ack1", 32'(ackid8), 32'h1);
    expect_eq("conf_ackv1", 32'(ackv8), 32'h1);
    expect_eq("conf_reset", 32'(flags8[3]), 32'h0);

    // clr_all with a command in the apply stage
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, i);
      cycle();
    end
    set_req(0, 1'b1, 0);
    cycle();
    expect_eq("clr_pre_flags", 32'(flags8), 32'hFF);
    clr_all = 1'b1; req_valid = 4'b0010; set_req(1, 1'b1, 4); #1;
    expect_eq("clr_ready", 32'(rdy8), 32'h0);
    cycle();
    expect_eq("clr_flags", 32'(flags8), 32'h00);
    expect_eq("clr_ackv", 32'(ackv8), 32'h0);
    clr_all = 1'b0; req_valid = 4'b0000;
    cycle();
    expect_eq("clr_no_ack", 32'(ackv8), 32'h0);

    // Out-of-range index on the 6-flag instance
    set_req(1, 1'b1, 7); req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0000;
    cycle();
    expect_eq("err_ackv", 32'(ackv6), 32'h1);
    expect_eq("err_ackid", 32'(ackid6), 32'h1);
    expect_eq("err_set", 32'(err6), 32'h1);
    expect_eq("err_flags6", 32'(flags6), 32'h00);
    expect_eq("err_flags8", 32'(flags8), 32'h80);
    expect_eq("err8_clear", 32'(err8), 32'h0);
    cycle(); cycle();
    expect_eq("err_sticky", 32'(err6), 32'h1);
    clr_all = 1'b1;
    cycle();
    clr_all = 1'b0;
    expect_eq("err_cleared", 32'(err6), 32'h0);

    // Async reset between accept and apply
    set_req(0, 1'b1, 2); req_valid = 4'b0001;
    cycle();
    set_req(0, 1'b1, 4);
    cycle();
    req_valid = 4'b0000;
    expect_eq("ar_pre_flags", 32'(flags8), 32'h04);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_eq("ar_flags", 32'(flags8), 32'h00);
    expect_eq("ar_ackv", 32'(ackv8), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    expect_eq("ar_no_ack", 32'(ackv8), 32'h0);
    expect_eq("ar_flags_after", 32'(flags8), 32'h00);

    // Randomized traffic: requesters hold a command until it is accepted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || m_acc == i) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
      end
      clr_all = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    clr_all = 1'b0;
    req_valid = 4'b0000;
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shares a bank of NFLAG set/reset flag bits between NREQ independent requesters.
- Semantics per flag match our edge-triggered SR flop: each flag is set or reset on a clock edge and holds otherwise.
- Round-robin arbitration accepts at most one set/reset command per cycle.
- Accepted commands pass through a one-stage apply pipeline, and each completion is acknowledged back to the issuing requester.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NFLAG, 8, number of flag bits in the bank (1..256).
- IDXW, $clog2(NFLAG) (min 1), width of a flag index.
- IDW, $clog2(NREQ) (min 1), width of a requester id.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester command valid.
- req_op  input  NREQ  per-requester op: 1 = SET, 0 = RESET.
- req_idx  input  NREQ*IDXW  per-requester flag index; requester i uses bits [i*IDXW +: IDXW].
- req_ready  output  NREQ  one-hot or zero; grant for the current cycle.
- clr_all  input  1  synchronous clear of the whole bank.
- flags  output  NFLAG  registered flag bank.
- ack_valid  output  1  one-cycle pulse when a command has been applied.
- ack_id  output  IDW  requester id of the applied command.
- err  output  1  sticky out-of-range index flag.

Behaviour:
- Reset (rst_n = 0, async):
  - flags = 0, ack_valid = 0, ack_id = 0, err = 0.
  - rr_ptr = 0, apply stage empty.
  - req_ready = 0 while rst_n is low.
  - Reset asserted mid-operation drops any in-flight command, with no ack.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ. The first valid requester gets req_ready = 1; all others get 0.
  - Accept = req_valid[i] & req_ready[i]. Requesters hold valid, op and idx stable until accepted.
  - On accept of i: rr_ptr <= (i+1) mod NREQ. Without an accept, rr_ptr holds.
- Apply stage (registered):
  - On accept, capture {op, idx, id} and set stage_v.
  - At the next edge, if stage_v:
    - idx < NFLAG: flags[idx] <= op (SET -> 1, RESET -> 0).
    - idx >= NFLAG: flags unchanged, err <= 1.
  - In both cases ack_valid <= 1 and ack_id <= id for exactly one cycle.
  - Latency: accept at edge k; flag update and ack_valid high after edge k+1.
  - Throughput is one command per cycle. Back-to-back accepts are allowed, and the stage is overwritten each cycle.
- Ordering: a later accepted command on the same flag wins because commands apply in acceptance order. The same requester repeating SET on a set flag leaves the flag unchanged but is still acked.
- Simultaneous requests to the same flag (SET from one requester, RESET from another) are serialised by round-robin. There is no inherent set priority at the bank level.
- clr_all:
  - When high at an edge: flags <= 0, err <= 0, stage_v <= 0. The in-flight command is dropped with no ack, and ack_valid <= 0.
  - req_ready forced to 0 in that cycle (nothing accepted); rr_ptr holds.
  - clr_all overrides an apply targeting the same edge.
- Wrap-around: rr_ptr = NREQ-1 followed by an accept of NREQ-1 gives rr_ptr = 0.
- Fairness: under continuous requests from all requesters, each is granted once every NREQ cycles.

Decomposition:
- Package sr_ctrl_pkg:
  - OP_RESET = 1'b0, OP_SET = 1'b1.
  - Function clog2_min1.
  - Packed struct sr_cmd_t {op, idx, id} for the apply stage.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: clk, rst_n, req[N], advance.
  - Outputs: gnt[N] one-hot, gnt_id.
  - Holds rr_ptr internally.
- The top level holds the apply stage, the flag bank and err.

Test Plan:
- Reset then idle: after rst_n rises, flags = 8'h00, req_ready = 0, ack_valid = 0, err = 0 for 5 cycles.
- Single set: requester 2 issues SET idx 5 -> req_ready = 4'b0100 in cycle k; after edge k+1, flags = 8'h20, ack_valid pulse with ack_id = 2.
- Fairness: all four requesters hold valid with SET idx = id, starting at rr_ptr = 0 -> grant order 0,1,2,3,0 on consecutive cycles; flags = 8'h0F after the 4th ack.
- Conflict: requester 0 issues SET idx 3 while requester 1 issues RESET idx 3 in the same cycle, rr_ptr = 0 -> SET applied first, then RESET; final flags[3] = 0, acks with id 0 then id 1.
- clr_all with an op in the apply stage: flags = 8'hFF, accept SET idx 0, assert clr_all on the next edge -> flags = 8'h00, no ack, req_ready = 0 that cycle.
- Error and async reset:
  - NFLAG = 6, requester 1 issues SET idx 7 -> flags unchanged, ack_id = 1, err = 1 (sticky until clr_all).
  - Drop rst_n between accept and apply -> no ack, flags = 0 immediately.
